// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared definitions for the memory stage of the 16-bit core: datapath width
//   default, branch condition codes, flag bit positions and FSM state encodings.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    // Default datapath and address width.
    localparam int DW_DEFAULT = 16;

    // Position of each flag inside the {V,Z,N} flag register.
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Branch condition codes (ex_cond).
    localparam logic [2:0] COND_NEQ    = 3'b000; // Z=0
    localparam logic [2:0] COND_EQ     = 3'b001; // Z=1
    localparam logic [2:0] COND_GT     = 3'b010; // Z=0 & N=0
    localparam logic [2:0] COND_NEG    = 3'b011; // N=1
    localparam logic [2:0] COND_GE     = 3'b100; // Z=1 | N=0
    localparam logic [2:0] COND_LE     = 3'b101; // Z=1 | N=1
    localparam logic [2:0] COND_OVF    = 3'b110; // V=1
    localparam logic [2:0] COND_UNCOND = 3'b111; // always

    // Memory-access FSM states.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

endpackage : mem_stage_pkg

// File: rtl/mem_stage_branch_eval.sv
// -----------------------------------------------------------------------------
// branch_eval
//   Purely combinational branch resolution: decides whether a branch with
//   condition code `cond` is taken against the flag register `flags`.
//
// Ports:
//   cond   in  3  branch condition code (COND_* in mem_stage_pkg)
//   flags  in  3  {V,Z,N} flag register
//   taken  out 1  branch is taken
// -----------------------------------------------------------------------------
module branch_eval
    import mem_stage_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic v;
    logic z;
    logic n;

    assign v = flags[FLAG_V];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEQ:    taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~n;
            COND_NEG:    taken = n;
            COND_GE:     taken = z | ~n;
            COND_LE:     taken = z | n;
            COND_OVF:    taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule : branch_eval

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Pipeline stage after execute. Holds the {V,Z,N} flag register, resolves
//   branches/jumps into a registered one-cycle PC redirect, performs loads and
//   stores against a ready-handshake data memory, and produces registered
//   write-back results. The execute stage is stalled while an access waits.
//
// Configuration:
//   DM_TIMEOUT_EN  when defined, a wait counter aborts an access that has not
//                  seen dm_ready after TIMEOUT_CYCLES wait cycles and sets the
//                  sticky dm_err output. When undefined, WAIT waits forever and
//                  neither the counter nor dm_err exists.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   ex_*                     instruction from execute (valid, result, flags,
//                            targets, decode bits, cond, dst)
//   ex_stall                 execute must hold; instruction not accepted
//   redirect, redirect_pc    one-cycle fetch redirect and its target
//   dm_req/we/addr/wdata     data memory request
//   dm_rdata, dm_ready       data memory response
//   wb_valid/we/dst/data     registered write-back
//   flags_q                  {V,Z,N} flag register
//   dm_err                   sticky access timeout (DM_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEFAULT
`ifdef DM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ex_valid,
    input  logic [DW-1:0] ex_alu_result,
    input  logic          ex_v,
    input  logic          ex_z,
    input  logic          ex_n,
    input  logic          ex_set_flags,
    input  logic [DW-1:0] ex_store_data,
    input  logic [DW-1:0] ex_branch_target,
    input  logic [DW-1:0] ex_jump_target,
    input  logic          ex_is_load,
    input  logic          ex_is_store,
    input  logic          ex_is_branch,
    input  logic          ex_is_jump,
    input  logic [2:0]    ex_cond,
    input  logic          ex_reg_write,
    input  logic [3:0]    ex_dst,
    output logic          ex_stall,

    output logic          redirect,
    output logic [DW-1:0] redirect_pc,

    output logic          dm_req,
    output logic          dm_we,
    output logic [DW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    input  logic          dm_ready,
`ifdef DM_TIMEOUT_EN
    output logic          dm_err,
`endif

    output logic          wb_valid,
    output logic          wb_we,
    output logic [3:0]    wb_dst,
    output logic [DW-1:0] wb_data,
    output logic [2:0]    flags_q
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e        state_q,       state_d;
    logic [2:0]    flags_d;

    // Captured memory access, held stable for the whole WAIT period.
    logic [DW-1:0] addr_q,        addr_d;
    logic [DW-1:0] wdata_q,       wdata_d;
    logic          we_q,          we_d;
    logic [3:0]    dst_q,         dst_d;

    logic          redirect_q,    redirect_d;
    logic [DW-1:0] redirect_pc_q, redirect_pc_d;

    logic          wb_valid_q,    wb_valid_d;
    logic          wb_we_q,       wb_we_d;
    logic [3:0]    wb_dst_q,      wb_dst_d;
    logic [DW-1:0] wb_data_q,     wb_data_d;

`ifdef DM_TIMEOUT_EN
    // Value of the wait counter in the last WAIT cycle before abort.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0]    wait_cnt_q,    wait_cnt_d;
    logic          dm_err_q,      dm_err_d;

    assign dm_err = dm_err_q;
`endif

    logic accept;
    logic taken;
    logic is_mem;

    // ------------------------------------------------------------------
    // Branch resolution against the flags left by the last older setter
    // ------------------------------------------------------------------
    branch_eval u_branch_eval (
        .cond  (ex_cond),
        .flags (flags_q),
        .taken (taken)
    );

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    assign ex_stall    = (state_q == S_WAIT);
    assign dm_req      = (state_q == S_WAIT);
    assign dm_we       = dm_req & we_q;
    assign dm_addr     = addr_q;
    assign dm_wdata    = wdata_q;

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

    assign wb_valid    = wb_valid_q;
    assign wb_we       = wb_we_q;
    assign wb_dst      = wb_dst_q;
    assign wb_data     = wb_data_q;

    // The instruction presented during a redirect cycle is on the wrong path.
    assign accept = ex_valid & ~ex_stall & ~redirect_q;
    assign is_mem = ex_is_load | ex_is_store;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        flags_d       = flags_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        dst_d         = dst_q;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        wb_valid_d    = 1'b0;
        wb_we_d       = 1'b0;
        wb_dst_d      = '0;
        wb_data_d     = '0;
`ifdef DM_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        dm_err_d      = dm_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (ex_set_flags) begin
                        flags_d = {ex_v, ex_z, ex_n};
                    end

                    if (is_mem) begin
                        state_d = S_WAIT;
                        addr_d  = ex_alu_result;
                        wdata_d = ex_store_data;
                        we_d    = ex_is_store;
                        dst_d   = ex_dst;
`ifdef DM_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end else begin
                        // ALU, branch and jump (link value in ex_alu_result).
                        wb_valid_d = 1'b1;
                        wb_we_d    = ex_reg_write;
                        wb_dst_d   = ex_dst;
                        wb_data_d  = ex_alu_result;

                        if (ex_is_jump) begin
                            redirect_d    = 1'b1;
                            redirect_pc_d = ex_jump_target;
                        end else if (ex_is_branch && taken) begin
                            redirect_d    = 1'b1;
                            redirect_pc_d = ex_branch_target;
                        end
                    end
                end
            end

            S_WAIT: begin
                if (dm_ready) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = ~we_q;
                    wb_dst_d   = dst_q;
                    wb_data_d  = we_q ? '0 : dm_rdata;
`ifdef DM_TIMEOUT_EN
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Abandon the access: no write-back, flag the error.
                    state_d  = S_IDLE;
                    dm_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            flags_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            dst_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_dst_q      <= '0;
            wb_data_q     <= '0;
`ifdef DM_TIMEOUT_EN
            wait_cnt_q    <= '0;
            dm_err_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            dst_q         <= dst_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_dst_q      <= wb_dst_d;
            wb_data_q     <= wb_data_d;
`ifdef DM_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            dm_err_q      <= dm_err_d;
`endif
        end
    end

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage. A sequential driver issues directed and
//   random instructions, plays the data memory, and pushes expected write-back
//   and redirect events into queues from an instruction-level model. A monitor
//   on the falling edge pops and compares whenever the DUT presents an event.
//   Define DM_TIMEOUT_EN to also exercise the access timeout (limit 4).
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int DW = 16;

    typedef enum int {K_ALU, K_BR, K_JMP, K_LD, K_ST} kind_e;

    typedef struct {
        kind_e       kind;
        logic [15:0] alu;
        logic [15:0] sdata;
        logic [15:0] btgt;
        logic [15:0] jtgt;
        logic        v, z, n;
        logic        set_flags;
        logic        reg_write;
        logic [2:0]  cond;
        logic [3:0]  dst;
    } instr_t;

    typedef struct {
        logic [15:0] data;
        logic        we;
        logic [3:0]  dst;
        bit          chk_data;
    } wb_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid;
    logic [DW-1:0] ex_alu_result;
    logic          ex_v, ex_z, ex_n;
    logic          ex_set_flags;
    logic [DW-1:0] ex_store_data;
    logic [DW-1:0] ex_branch_target;
    logic [DW-1:0] ex_jump_target;
    logic          ex_is_load, ex_is_store, ex_is_branch, ex_is_jump;
    logic [2:0]    ex_cond;
    logic          ex_reg_write;
    logic [3:0]    ex_dst;
    logic          ex_stall;
    logic          redirect;
    logic [DW-1:0] redirect_pc;
    logic          dm_req, dm_we;
    logic [DW-1:0] dm_addr, dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          wb_valid, wb_we;
    logic [3:0]    wb_dst;
    logic [DW-1:0] wb_data;
    logic [2:0]    flags_q;
`ifdef DM_TIMEOUT_EN
    logic          dm_err;
`endif

    int errors = 0;
    int checks = 0;

    wb_exp_t     wb_q[$];
    logic [15:0] rd_q[$];

    // Instruction-level model state.
    logic [2:0] m_flags = 3'b000;  // {V,Z,N}
    bit         squash_next = 0;   // a redirect is on its way: next cycle is wrong-path
    bit         mon_en = 0;

    always #5 clk = ~clk;

    mem_stage #(
        .DW(DW)
`ifdef DM_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_alu_result    (ex_alu_result),
        .ex_v             (ex_v),
        .ex_z             (ex_z),
        .ex_n             (ex_n),
        .ex_set_flags     (ex_set_flags),
        .ex_store_data    (ex_store_data),
        .ex_branch_target (ex_branch_target),
        .ex_jump_target   (ex_jump_target),
        .ex_is_load       (ex_is_load),
        .ex_is_store      (ex_is_store),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .ex_cond          (ex_cond),
        .ex_reg_write     (ex_reg_write),
        .ex_dst           (ex_dst),
        .ex_stall         (ex_stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .dm_req           (dm_req),
        .dm_we            (dm_we),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_rdata         (dm_rdata),
        .dm_ready         (dm_ready),
`ifdef DM_TIMEOUT_EN
        .dm_err           (dm_err),
`endif
        .wb_valid         (wb_valid),
        .wb_we            (wb_we),
        .wb_dst           (wb_dst),
        .wb_data          (wb_data),
        .flags_q          (flags_q)
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Branch rule table written directly from the condition definitions.
    function automatic bit model_taken(input logic [2:0] c, input logic [2:0] f);
        bit v, z, n;
        v = f[2]; z = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return z || n;
            3'd6: return v;
            default: return 1;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.kind      = kind_e'($urandom_range(0, 4));
        i.alu       = 16'($urandom());
        i.sdata     = 16'($urandom());
        i.btgt      = 16'($urandom());
        i.jtgt      = 16'($urandom());
        i.v         = 1'($urandom());
        i.z         = 1'($urandom());
        i.n         = 1'($urandom());
        i.set_flags = 1'($urandom());
        i.reg_write = 1'($urandom());
        i.cond      = 3'($urandom());
        i.dst       = 4'($urandom());
        return i;
    endfunction

    function automatic instr_t mk(input kind_e k, input logic [15:0] alu, input logic [3:0] dst);
        instr_t i;
        i = rand_instr();
        i.kind = k; i.alu = alu; i.dst = dst;
        i.set_flags = 1'b0; i.reg_write = 1'b1;
        return i;
    endfunction

    task automatic drive_fields(input instr_t i, input logic valid);
        ex_valid         = valid;
        ex_alu_result    = i.alu;
        ex_v             = i.v;
        ex_z             = i.z;
        ex_n             = i.n;
        ex_set_flags     = i.set_flags;
        ex_store_data    = i.sdata;
        ex_branch_target = i.btgt;
        ex_jump_target   = i.jtgt;
        ex_is_load       = (i.kind == K_LD);
        ex_is_store      = (i.kind == K_ST);
        ex_is_branch     = (i.kind == K_BR);
        ex_is_jump       = (i.kind == K_JMP);
        ex_cond          = i.cond;
        ex_reg_write     = i.reg_write;
        ex_dst           = i.dst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with no instruction; dm_ready noise must be ignored in IDLE.
    task automatic idle_cycle();
        drive_fields(rand_instr(), 1'b0);
        dm_ready = 1'($urandom());
        dm_rdata = 16'($urandom());
        tick();
        squash_next = 0;
    endtask

    // WAIT phase of an accepted load/store; memory answers in WAIT cycle wait_n.
    task automatic mem_phase(input instr_t ins, input int wait_n, input logic [15:0] rdata);
        wb_exp_t e;
        for (int k = 1; k <= wait_n; k++) begin
            check("wait_stall", ex_stall, 1'b1);
            check("wait_dm_req", dm_req, 1'b1);
            check("wait_dm_addr", dm_addr, ins.alu);
            check("wait_dm_we", dm_we, ins.kind == K_ST);
            if (ins.kind == K_ST) check("wait_dm_wdata", dm_wdata, ins.sdata);
            // A stalled instruction is offered meanwhile; it must be ignored.
            drive_fields(rand_instr(), 1'b1);
            dm_ready = (k == wait_n);
            dm_rdata = (k == wait_n) ? rdata : 16'($urandom());
            if (k == wait_n) begin
                e.data     = rdata;
                e.we       = (ins.kind == K_LD);
                e.dst      = ins.dst;
                e.chk_data = (ins.kind == K_LD);
                wb_q.push_back(e);
            end
            tick();
        end
        dm_ready = 1'b0;
        ex_valid = 1'b0;
        check("post_ready_dm_req", dm_req, 1'b0);
        check("post_ready_stall", ex_stall, 1'b0);
        check("flags_after_mem", flags_q, m_flags);
    endtask

    task automatic run_instr(input instr_t ins, input int wait_n, input logic [15:0] rdata);
        bit      squashed;
        bit      tk;
        wb_exp_t e;
        drive_fields(ins, 1'b1);
        if (ins.kind != K_LD && ins.kind != K_ST) begin
            dm_ready = 1'($urandom());
            dm_rdata = 16'($urandom());
        end else begin
            dm_ready = 1'b0;
        end
        check("issue_stall", ex_stall, 1'b0);
        squashed = squash_next;
        tk = model_taken(ins.cond, m_flags);
        tick();
        squash_next = 0;
        if (!squashed) begin
            if (ins.kind == K_ALU || ins.kind == K_BR || ins.kind == K_JMP) begin
                e.data = ins.alu; e.we = ins.reg_write; e.dst = ins.dst; e.chk_data = 1;
                wb_q.push_back(e);
            end
            if (ins.kind == K_JMP) begin
                rd_q.push_back(ins.jtgt);
                squash_next = 1;
            end else if (ins.kind == K_BR && tk) begin
                rd_q.push_back(ins.btgt);
                squash_next = 1;
            end
            if (ins.set_flags) m_flags = {ins.v, ins.z, ins.n};
        end
        check("flags", flags_q, m_flags);
        if (!squashed && (ins.kind == K_LD || ins.kind == K_ST)) begin
            mem_phase(ins, wait_n, rdata);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        wb_exp_t     e;
        logic [15:0] pc;
        if (mon_en) begin
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", wb_valid, 1'b0);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_we", wb_we, e.we);
                    if (e.chk_data) begin
                        check("wb_dst", wb_dst, e.dst);
                        check("wb_data", wb_data, e.data);
                    end
                end
            end else begin
                check("wb_we_idle", wb_we, 1'b0);
            end
            if (redirect) begin
                if (rd_q.size() == 0) begin
                    check("redirect_unexpected", redirect, 1'b0);
                end else begin
                    pc = rd_q.pop_front();
                    check("redirect_pc", redirect_pc, pc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        instr_t i;
        rst = 1'b1;
        drive_fields(rand_instr(), 1'b0);
        dm_ready = 1'b0;
        dm_rdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_stall", ex_stall, 1'b0);
        check("rst_redirect", redirect, 1'b0);
        check("rst_redirect_pc", redirect_pc, 16'h0);
        check("rst_dm_req", dm_req, 1'b0);
        check("rst_dm_we", dm_we, 1'b0);
        check("rst_dm_addr", dm_addr, 16'h0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_data", wb_data, 16'h0);
        check("rst_flags", flags_q, 3'b000);
`ifdef DM_TIMEOUT_EN
        check("rst_dm_err", dm_err, 1'b0);
`endif
        mon_en = 1;

        // Back-to-back ALU ops.
        run_instr(mk(K_ALU, 16'h0005, 4'd3), 1, 16'h0);
        run_instr(mk(K_ALU, 16'h00FF, 4'd4), 1, 16'h0);
        idle_cycle();

        // Set Z, then BEQ to 0x0040; the following instruction is squashed.
        i = mk(K_ALU, 16'h0000, 4'd1);
        i.set_flags = 1'b1; i.v = 1'b0; i.z = 1'b1; i.n = 1'b0;
        run_instr(i, 1, 16'h0);
        i = mk(K_BR, 16'h0011, 4'd0);
        i.cond = 3'b001; i.btgt = 16'h0040; i.reg_write = 1'b0;
        run_instr(i, 1, 16'h0);
        i = mk(K_ALU, 16'h7777, 4'd7);
        i.set_flags = 1'b1; i.v = 1'b1; i.z = 1'b0; i.n = 1'b1;
        run_instr(i, 1, 16'h0);
        check("squash_flags", flags_q, 3'b010);
        idle_cycle();

        // Load from 0x1234, ready in the third WAIT cycle.
        run_instr(mk(K_LD, 16'h1234, 4'd5), 3, 16'hBEEF);

        // Store 0xA5A5 to 0x0010 with immediate ready.
        i = mk(K_ST, 16'h0010, 4'd0);
        i.sdata = 16'hA5A5;
        run_instr(i, 1, 16'h0);

        // Overflow branch with V=0: not taken.
        i = mk(K_BR, 16'h0022, 4'd2);
        i.cond = 3'b110; i.btgt = 16'h0099;
        run_instr(i, 1, 16'h0);
        idle_cycle();

        // Reset in the middle of WAIT.
        i = mk(K_LD, 16'h0400, 4'd6);
        i.set_flags = 1'b1; i.v = 1'b1; i.z = 1'b1; i.n = 1'b1;
        drive_fields(i, 1'b1);
        dm_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        tick();
        check("pre_rst_dm_req", dm_req, 1'b1);
        check("pre_rst_flags", flags_q, 3'b111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_flags = 3'b000;
        squash_next = 0;
        check("mid_rst_dm_req", dm_req, 1'b0);
        check("mid_rst_stall", ex_stall, 1'b0);
        check("mid_rst_wb_valid", wb_valid, 1'b0);
        check("mid_rst_flags", flags_q, 3'b000);
        idle_cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                run_instr(rand_instr(), int'($urandom_range(1, 3)), 16'($urandom()));
            end
        end
        idle_cycle();

`ifdef DM_TIMEOUT_EN
        // Load with no response: aborted after 4 WAIT cycles.
        run_instr(mk(K_ALU, 16'h0001, 4'd1), 1, 16'h0);
        idle_cycle();
        drive_fields(mk(K_LD, 16'h0BAD, 4'd9), 1'b1);
        dm_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("to_dm_req", dm_req, 1'b1);
            tick();
        end
        check("to_abort_dm_req", dm_req, 1'b0);
        check("to_abort_stall", ex_stall, 1'b0);
        check("to_dm_err", dm_err, 1'b1);
        idle_cycle();
        idle_cycle();
        check("to_dm_err_sticky", dm_err, 1'b1);
`endif

        idle_cycle();
        idle_cycle();
        check("wb_queue_drained", wb_q.size(), 0);
        check("redirect_queue_drained", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_stage
